uart_boot_loader: RTL
=====================

Name: uart_boot_loader

Overview:
- Parametrised successor to the current software-upgrade path: it receives a framed byte stream from the UART RX side and writes it into instruction/data RAM.
- Holds the core in reset while an upgrade is in progress.
- Adds what the old path lacks: explicit frame header with load address and word count, checksum, inter-byte timeout, range check, and error reporting.
- Sits between the uart_mgr RX byte output and the SoC RAM write mux. `ram_wr_en` selects this block as the RAM port-A master.

Parameters:
- XLEN, 32, RAM data width in bits; must be a multiple of 8; BPW = XLEN/8 bytes per word.
- RAM_ADDR_LEN, 14, word-address width of the RAM.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 5000000, maximum idle clocks between bytes inside a frame.

Ports:
- clk  input  1  system clock
- rstb  input  1  asynchronous active-low reset
- upgrade_req_b  input  1  active-low upgrade enable level (from sw_uart_upgrade_b, already synchronised)
- rx_valid  input  1  received byte available
- rx_data  input  8  received byte
- rx_ready  output  1  byte consumed when rx_valid & rx_ready
- ram_wr_en  output  1  loader owns the RAM port this cycle
- ram_addr  output  RAM_ADDR_LEN  RAM word address
- ram_we  output  XLEN/8  byte write enables
- ram_wr_data  output  XLEN  write data
- during_sw_upgrade  output  1  core reset hold
- upg_done  output  1  last frame good
- upg_err  output  2  0 none, 1 checksum, 2 timeout, 3 range

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Frame format, little-endian:
  - SYNC byte.
  - ADDR_L, ADDR_H: start word address, 16 bits.
  - LEN_L, LEN_H: word count N, 16 bits.
  - N×BPW payload bytes, byte 0 of each word = bits [7:0].
  - CSUM byte.
- Checksum rule: the 8-bit sum of all bytes after SYNC, including CSUM, must equal 0.
- States: IDLE, WAIT_SYNC, HDR, DATA, WRITE, CSUM, DONE, ERR.
- IDLE:
  - Entered on reset or whenever upgrade_req_b=1 (any state; takes priority over everything).
  - rx_ready=0, during_sw_upgrade=0.
  - upg_done/upg_err keep last values.
  - upgrade_req_b=0 → WAIT_SYNC.
- WAIT_SYNC:
  - rx_ready=1, during_sw_upgrade=1.
  - Bytes other than SYNC_BYTE are discarded.
  - SYNC_BYTE → HDR; clear upg_done, upg_err, checksum, and byte counter.
- HDR:
  - Collect 4 bytes.
  - After LEN_H: if ADDR+N > 2^RAM_ADDR_LEN (17-bit compare), go to ERR with code 3. No RAM write occurs.
  - Else if N=0 → CSUM.
  - Else → DATA.
- DATA:
  - Shift bytes into the word buffer.
  - On the BPW-th byte → WRITE, with rx_ready=0 for that cycle.
- WRITE (one cycle):
  - ram_wr_en=1, ram_we=all ones, ram_addr=current address, ram_wr_data=buffer.
  - Next cycle: address+1, remaining−1.
  - Remaining becomes 0 → CSUM; else → DATA.
  - Consequence: each word costs BPW accepted bytes plus 1 write cycle. rx_ready is low only in WRITE.
- CSUM:
  - One byte.
  - Sum==0 → DONE, upg_done=1.
  - Else → ERR, upg_err=1.
- DONE:
  - during_sw_upgrade=0 so the core boots; rx_ready=0.
  - Stay until upgrade_req_b=1 → IDLE.
  - A new upgrade needs a release/re-assert of upgrade_req_b.
- ERR:
  - during_sw_upgrade stays 1, so the core is held.
  - rx_ready=1.
  - SYNC_BYTE restarts the frame as in WAIT_SYNC; upg_err is cleared on that restart.
- Timeout:
  - Counter resets on each accepted byte and on entry to HDR.
  - Counts in HDR, DATA, CSUM.
  - Reaching TIMEOUT_CYC → ERR, upg_err=2.
  - Partially received words are never written.
- ram_wr_en is 1 only in WRITE.
  - Words already written before an error remain in RAM; the core stays in reset.
- Address increment wraps modulo 2^RAM_ADDR_LEN. The range check guarantees no wrap in a legal frame.
- rx_valid while rx_ready=0: the byte is held by the source and not consumed.
- upgrade_req_b=1 in the middle of a frame aborts immediately to IDLE. No further writes; an in-flight WRITE cycle is dropped.
- Async reset mid-frame: all state and outputs return to their reset values on the next rstb low.

Test Plan:
1. BPW=4, upgrade_req_b=0, frame A5 10 00 02 00 78 56 34 12 EF BE AD DE CS (CS makes the sum 0) → two writes: addr 0x10 data 0x12345678, addr 0x11 data 0xDEADBEEF, ram_we=4'hF; then upg_done=1, during_sw_upgrade falls.
2. Same frame with CS+1 → both writes occur; upg_err=1, during_sw_upgrade stays 1. Resend the good frame → upg_err=0, upg_done=1.
3. RAM_ADDR_LEN=14, ADDR=0x3FFF, LEN=2 → after LEN_H: upg_err=3, zero ram_wr_en pulses.
4. TIMEOUT_CYC=100; send A5 00 00 01 00 11 22, then idle 100 clocks → upg_err=2, no write.
5. Garbage 00 FF 5A before A5, then a LEN=0 frame A5 00 00 00 00 00 → no writes, upg_done=1.
6. Assert upgrade_req_b=1 after 3 payload bytes → state IDLE, rx_ready=0, during_sw_upgrade=0 next cycle, no write. Also pulse rstb low mid-frame → all outputs 0.

Source files
------------

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses SYNC/ADDR/LEN/payload/CSUM frames from the RX byte stream,
// writes whole words into RAM and holds the core in reset while an upgrade is in progress.
module uart_boot_loader #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RAM_ADDR_LEN = 14,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC  = 5000000
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    upgrade_req_b,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rx_ready,
  output logic                    ram_wr_en,
  output logic [RAM_ADDR_LEN-1:0] ram_addr,
  output logic [XLEN/8-1:0]       ram_we,
  output logic [XLEN-1:0]         ram_wr_data,
  output logic                    during_sw_upgrade,
  output logic                    upg_done,
  output logic [1:0]              upg_err
);

  localparam int unsigned BPW   = XLEN / 8;
  localparam int unsigned ByteW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrCsum    = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;
  localparam logic [1:0] ErrRange   = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StWaitSync, StHdr, StData, StWrite, StCsum, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [ByteW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [7:0]        csum_q, csum_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              rx_ready_q, wr_en_q, during_q;

  logic              accept;
  logic              tmo_last;
  logic [15:0]       len_new;
  logic [16:0]       end_addr;
  logic              range_bad;

  assign accept    = rx_valid & rx_ready_q;
  assign tmo_last  = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
  assign len_new   = {rx_data, len_q[7:0]};
  // 17-bit end address so a 16-bit ADDR+N cannot wrap past the check.
  assign end_addr  = {1'b0, addr_q} + {1'b0, len_new};
  assign range_bad = end_addr > 17'(1 << RAM_ADDR_LEN);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    hdr_cnt_d  = hdr_cnt_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    csum_d     = csum_q;
    tmo_d      = tmo_q;
    done_d     = done_q;
    err_d      = err_q;

    if (upgrade_req_b) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StWaitSync;
        StWaitSync, StErr: begin
          if (accept && rx_data == SYNC_BYTE) begin
            state_d    = StHdr;
            done_d     = 1'b0;
            err_d      = ErrNone;
            csum_d     = 8'h00;
            hdr_cnt_d  = 2'd0;
            byte_cnt_d = '0;
            tmo_d      = '0;
          end
        end
        StHdr: begin
          if (accept) begin
            csum_d    = csum_q + rx_data;
            tmo_d     = '0;
            hdr_cnt_d = hdr_cnt_q + 2'd1;
            unique case (hdr_cnt_q)
              2'd0: addr_d[7:0]  = rx_data;
              2'd1: addr_d[15:8] = rx_data;
              2'd2: len_d[7:0]   = rx_data;
              2'd3: begin
                len_d[15:8] = rx_data;
                if (range_bad) begin
                  state_d = StErr;
                  err_d   = ErrRange;
                end else if (len_new == 16'd0) begin
                  state_d = StCsum;
                end else begin
                  state_d = StData;
                end
              end
            endcase
          end else if (tmo_last) begin
            state_d = StErr;
            err_d   = ErrTimeout;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end
        StData: begin
          if (accept) begin
            csum_d = csum_q + rx_data;
            tmo_d  = '0;
            // Shift right so the first byte of a word ends up in bits [7:0].
            buf_d  = (buf_q >> 8) | (XLEN'(rx_data) << (XLEN - 8));
            if (byte_cnt_q == ByteW'(BPW - 1)) begin
              byte_cnt_d = '0;
              state_d    = StWrite;
            end else begin
              byte_cnt_d = byte_cnt_q + ByteW'(1);
            end
          end else if (tmo_last) begin
            state_d = StErr;
            err_d   = ErrTimeout;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end
        StWrite: begin
          addr_d  = addr_q + 16'd1;
          len_d   = len_q - 16'd1;
          state_d = (len_q == 16'd1) ? StCsum : StData;
        end
        StCsum: begin
          if (accept) begin
            tmo_d = '0;
            if (csum_q + rx_data == 8'h00) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StErr;
              err_d   = ErrCsum;
            end
          end else if (tmo_last) begin
            state_d = StErr;
            err_d   = ErrTimeout;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end
        StDone: state_d = StDone;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      hdr_cnt_q  <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= ErrNone;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      during_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      hdr_cnt_q  <= hdr_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rx_ready_q <= state_d inside {StWaitSync, StHdr, StData, StCsum, StErr};
      wr_en_q    <= (state_d == StWrite);
      during_q   <= state_d inside {StWaitSync, StHdr, StData, StWrite, StCsum, StErr};
    end
  end

  // An abort request kills a write already in flight.
  assign ram_wr_en         = wr_en_q & ~upgrade_req_b;
  assign ram_we            = {BPW{ram_wr_en}};
  assign ram_addr          = addr_q[RAM_ADDR_LEN-1:0];
  assign ram_wr_data       = buf_q;
  assign rx_ready          = rx_ready_q;
  assign during_sw_upgrade = during_q;
  assign upg_done          = done_q;
  assign upg_err           = err_q;

endmodule
